// File: rtl/reg_capture_fifo.sv
// reg_capture_fifo: show-ahead capture buffer with a registered occupancy count.
// A write that arrives while the buffer is full and nothing is being popped is
// dropped and recorded in the sticky overflow flag.
// Optional feature: define REG_CAPTURE_OVF_CNT_EN to add a saturating 8-bit
// dropped-write counter on ovf_cnt; without it ovf_cnt is tied to 0.
module reg_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [WIDTH-1:0]           data,
    output logic [WIDTH-1:0]           outa,
    output logic                       outa_valid,
    input  logic                       outa_ready,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic [7:0]                 ovf_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             drop;

    // Status flags come straight from the registered count, so full and empty
    // can never be high together.
    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign outa_valid = !empty;
    assign outa       = empty ? '0 : mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full buffer still accepts a
    // write when the head is being consumed.
    assign pop  = outa_valid && outa_ready;
    assign push = enable && (!full || pop);
    assign drop = enable && full && !pop;

    // Storage write port.
    // NOTE: storage is deliberately left out of reset; stale entries are never
    // visible because outa is masked while empty and count gates every read.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= data;
        end
    end

    // Pointers, occupancy count and sticky overflow flag.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // DEPTH is a power of two, so natural pointer wrap is modulo DEPTH.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef REG_CAPTURE_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;

    // Saturating count of dropped writes, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_cnt_q <= 8'h00;
        end else if (drop && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 8'h01;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    assign ovf_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_reg_capture_fifo.sv
// Testbench for reg_capture_fifo (DEPTH=4, WIDTH=8): directed vector table,
// hand-written wrap / saturation sequences and a randomized run, all checked
// against a queue-based reference model.
module tb_reg_capture_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic [WIDTH-1:0] outa;
    logic             outa_valid;
    logic             outa_ready = 1'b0;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [7:0]       ovf_cnt;

    reg_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .data       (data),
        .outa       (outa),
        .outa_valid (outa_valid),
        .outa_ready (outa_ready),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .ovf_cnt    (ovf_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: contents as a queue, plus overflow bookkeeping.
    logic [WIDTH-1:0] mq[$];
    bit               m_ovf = 1'b0;
    int               m_ovf_cnt = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] d;
        logic       rdy;
        logic [7:0] e_outa;
        int         e_count;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_update(input logic r, input logic e,
                                         input logic [7:0] d, input logic rd);
        bit do_pop;
        bit do_push;
        if (r) begin
            mq.delete();
            m_ovf     = 1'b0;
            m_ovf_cnt = 0;
        end else begin
            do_pop  = (mq.size() > 0) && rd;
            do_push = e && ((mq.size() < DEPTH) || do_pop);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(d);
            if (e && !do_push) begin
                m_ovf = 1'b1;
                if (m_ovf_cnt < 255) m_ovf_cnt++;
            end
        end
    endfunction

    task automatic compare_model(input string tag);
        logic [7:0] exp_outa;
        int         exp_ovf_cnt;
        exp_outa = (mq.size() > 0) ? mq[0] : 8'h00;
`ifdef REG_CAPTURE_OVF_CNT_EN
        exp_ovf_cnt = m_ovf_cnt;
`else
        exp_ovf_cnt = 0;
`endif
        check({tag, ".outa"},       32'(outa),       32'(exp_outa));
        check({tag, ".outa_valid"}, 32'(outa_valid), 32'(mq.size() > 0));
        check({tag, ".count"},      32'(count),      32'(mq.size()));
        check({tag, ".full"},       32'(full),       32'(mq.size() == DEPTH));
        check({tag, ".empty"},      32'(empty),      32'(mq.size() == 0));
        check({tag, ".overflow"},   32'(overflow),   32'(m_ovf));
        check({tag, ".ovf_cnt"},    32'(ovf_cnt),    32'(exp_ovf_cnt));
    endtask

    // Drive one cycle of inputs (called at a negedge), advance the model at the
    // posedge and compare at the following negedge.
    task automatic apply(input string tag, input logic r, input logic e,
                         input logic [7:0] d, input logic rd);
        reset      = r;
        enable     = e;
        data       = d;
        outa_ready = rd;
        @(posedge clk);
        model_update(r, e, d, rd);
        @(negedge clk);
        compare_model(tag);
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic [7:0] d,
                                input logic rd, input logic [7:0] eo, input int ec,
                                input logic ev);
        vec_t v;
        v.rst = r; v.en = e; v.d = d; v.rdy = rd;
        v.e_outa = eo; v.e_count = ec; v.e_ovf = ev;
        return v;
    endfunction

    initial begin
        // Single write / read, then empty-with-ready has no effect.
        vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA5, 0, 8'hA5, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h00, 0, 0));
        // Fill, overflow, drain in order.
        vecs.push_back(mk(0, 1, 8'h01, 0, 8'h01, 1, 0));
        vecs.push_back(mk(0, 1, 8'h02, 0, 8'h01, 2, 0));
        vecs.push_back(mk(0, 1, 8'h03, 0, 8'h01, 3, 0));
        vecs.push_back(mk(0, 1, 8'h04, 0, 8'h01, 4, 0));
        vecs.push_back(mk(0, 1, 8'h05, 0, 8'h01, 4, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h02, 3, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h03, 2, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h04, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h00, 0, 1));
        // Full with simultaneous write and pop.
        vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'h21, 0, 8'h21, 1, 0));
        vecs.push_back(mk(0, 1, 8'h22, 0, 8'h21, 2, 0));
        vecs.push_back(mk(0, 1, 8'h23, 0, 8'h21, 3, 0));
        vecs.push_back(mk(0, 1, 8'h24, 0, 8'h21, 4, 0));
        vecs.push_back(mk(0, 1, 8'h77, 1, 8'h22, 4, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h23, 3, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h24, 2, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h77, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h00, 0, 0));
        // Empty with write and ready: write only.
        vecs.push_back(mk(0, 1, 8'h5A, 1, 8'h5A, 1, 0));
        vecs.push_back(mk(0, 1, 8'h5B, 0, 8'h5A, 2, 0));
        vecs.push_back(mk(0, 1, 8'h5C, 0, 8'h5A, 3, 0));
        // Reset wins over a concurrent write; first write after reset lands.
        vecs.push_back(mk(1, 1, 8'h99, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'h3C, 0, 8'h3C, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h00, 0, 0));

        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            apply(tag, vecs[i].rst, vecs[i].en, vecs[i].d, vecs[i].rdy);
            check({tag, ".tbl_outa"},  32'(outa),       32'(vecs[i].e_outa));
            check({tag, ".tbl_count"}, 32'(count),      32'(vecs[i].e_count));
            check({tag, ".tbl_valid"}, 32'(outa_valid), 32'(vecs[i].e_count != 0));
            check({tag, ".tbl_full"},  32'(full),       32'(vecs[i].e_count == DEPTH));
            check({tag, ".tbl_empty"}, 32'(empty),      32'(vecs[i].e_count == 0));
            check({tag, ".tbl_ovf"},   32'(overflow),   32'(vecs[i].e_ovf));
        end

        // Streaming 12 words through with ready held high: three pointer wraps.
        apply("wrap.rst", 1, 0, 8'h00, 0);
        for (int i = 0; i < 12; i++) begin
            apply($sformatf("wrap%0d", i), 0, 1, 8'(8'h10 + i), 1);
            check($sformatf("wrap%0d.head", i), 32'(outa), 32'(8'h10 + i));
            check($sformatf("wrap%0d.count_le1", i), 32'(count <= 1), 32'd1);
        end
        apply("wrap.drain", 0, 0, 8'h00, 1);
        check("wrap.final_empty", 32'(empty), 32'd1);

        // Long run of dropped writes: counter saturates (or stays 0 without it).
        apply("sat.rst", 1, 0, 8'h00, 0);
        for (int i = 0; i < DEPTH; i++) apply("sat.fill", 0, 1, 8'(8'hC0 + i), 0);
        for (int i = 0; i < 300; i++) begin
            reset = 0; enable = 1; data = 8'(i); outa_ready = 0;
            @(posedge clk);
            model_update(0, 1, 8'(i), 0);
            @(negedge clk);
        end
        compare_model("sat");
`ifdef REG_CAPTURE_OVF_CNT_EN
        check("sat.ovf_cnt_255", 32'(ovf_cnt), 32'd255);
`else
        check("sat.ovf_cnt_0", 32'(ovf_cnt), 32'd0);
`endif
        check("sat.overflow", 32'(overflow), 32'd1);
        check("sat.head_kept", 32'(outa), 32'hC0);

        // Randomized traffic with occasional resets.
        apply("rnd.rst", 1, 0, 8'h00, 0);
        for (int i = 0; i < 2000; i++) begin
            logic r;
            logic e;
            logic rd;
            r  = ($urandom_range(0, 63) == 0);
            e  = ($urandom_range(0, 99) < 60);
            rd = ($urandom_range(0, 99) < 45);
            apply("rnd", r, e, 8'($urandom), rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_capture_fifo.md
REG_CAPTURE_FIFO -- requirements
Module: reg_capture_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data/outa width in bits.
REQ-002 Parameter DEPTH, default 4: buffer entries; power of 2, >= 2.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on posedge clk.
REQ-005 enable  input  1  initiator write strobe; data is valid when high.
REQ-006 data  input  WIDTH  write word from initiator.
REQ-007 outa  output  WIDTH  head-of-buffer word; 0 when buffer empty.
REQ-008 outa_valid  output  1  high when buffer non-empty.
REQ-009 outa_ready  input  1  consumer accepts head word when high with outa_valid.
REQ-010 full  output  1  high when count == DEPTH.
REQ-011 empty  output  1  high when count == 0.
REQ-012 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-013 overflow  output  1  sticky flag: at least one write dropped.
REQ-014 ovf_cnt  output  8  dropped-write counter (see Configuration).

Function
REQ-015 push = enable && (!full || pop); pop = outa_valid && outa_ready.
REQ-016 On push, data written at write pointer; write pointer increments modulo DEPTH.
REQ-017 On pop, read pointer increments modulo DEPTH; next entry presented on outa same cycle as the pointer update takes effect.
REQ-018 outa/outa_valid are show-ahead: driven from read-pointer entry, no extra read latency.
REQ-019 Write-to-visible latency 1 cycle: word pushed at edge N appears on outa with outa_valid after edge N (empty buffer, no bypass).
REQ-020 count: +1 on push-only, -1 on pop-only, unchanged on push+pop or neither.
REQ-021 Full with simultaneous enable and pop: write accepted, count stays DEPTH, full stays high.
REQ-022 Empty with simultaneous enable and outa_ready: no pop (outa_valid low), write accepted, count becomes 1.
REQ-023 enable && full && !pop: write dropped, buffer unchanged, overflow set to 1 at that edge.
REQ-024 overflow clears only on reset.
REQ-025 Pointers wrap DEPTH-1 -> 0 with no loss; ordering strictly FIFO across wrap.
REQ-026 full and empty derived from registered count; never both high.
REQ-027 outa_ready while empty has no effect.
REQ-028 Buffer storage contents are not reset; outa is masked to 0 while empty.

Reset
REQ-029 reset high at posedge clk: count=0, both pointers=0, outa_valid=0, outa=0, empty=1, full=0, overflow=0, ovf_cnt=0.
REQ-030 reset has priority over simultaneous enable/outa_ready; in-flight words are discarded.
REQ-031 First write accepted at the first edge after reset deasserts.

Configuration
REQ-032 Macro REG_CAPTURE_OVF_CNT_EN defined: ovf_cnt increments by 1 on each dropped write (REQ-023) and saturates at 255; cleared on reset only.
REQ-033 Macro REG_CAPTURE_OVF_CNT_EN undefined: ovf_cnt is constant 0, no counter logic; overflow flag behaviour is unchanged.

Verification
REQ-034 Reset, then write 0xA5 (enable 1 cycle) -> next cycle outa=0xA5, outa_valid=1, count=1; assert outa_ready -> following cycle empty=1, outa=0.
REQ-035 Write 0x01..0x04 back-to-back with outa_ready=0 -> full=1, count=4; write 0x05 -> overflow=1, ovf_cnt=1 (macro on) / 0 (macro off); drain -> reads 0x01..0x04 in order.
REQ-036 Full buffer, enable=1 data=0x77 with outa_ready=1 -> head popped, 0x77 accepted, count stays 4, overflow stays 0.
REQ-037 Continuous write/read of 0x10..0x1B (12 words, DEPTH=4) with outa_ready=1 -> every word read once in order across 3 pointer wraps, count never exceeds 1.
REQ-038 Buffer holding 3 words, reset asserted for 1 cycle with enable=1 -> count=0, empty=1, outa_valid=0, overflow=0; written word not captured.
REQ-039 Macro on, 300 writes while full with outa_ready=0 -> ovf_cnt=255 (saturated), overflow=1.
